// File: rtl/ras_ss_pkg.sv
// Shared types for the return-address shadow-stack checker.
package ras_ss_pkg;

    // Commit event kinds as carried on ev_type.
    typedef enum logic [1:0] {
        EvNone = 2'd0,
        EvCall = 2'd1,
        EvRet  = 2'd2
    } ev_type_e;

    // Checker FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCmp   = 2'd1,
        StFault = 2'd2
    } chk_state_e;

    // Raw encoding 3 is reserved and behaves exactly like a NONE event.
    function automatic ev_type_e decode_ev(input logic [1:0] raw);
        ev_type_e kind;
        case (raw)
            2'd1:    kind = EvCall;
            2'd2:    kind = EvRet;
            default: kind = EvNone;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/ras_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module ras_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MaxVal = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ras_shadow_checker.sv
// Return-address checker: mirrors CALL/RET commits onto an external shadow stack and
// flags a RET whose target differs from the address pushed by the matching CALL.
module ras_shadow_checker
    import ras_ss_pkg::*;
#(
    parameter int unsigned DATA_W           = 32,
    parameter int unsigned CNT_W            = 16,
    parameter bit          STRICT_UNDERFLOW = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    // Commit event stream
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic [1:0]        ev_type,
    input  logic [DATA_W-1:0] ev_addr,
    // External shadow stack
    output logic              ss_push,
    output logic [DATA_W-1:0] ss_wdata,
    input  logic              ss_full,
    output logic              ss_pop,
    input  logic [DATA_W-1:0] ss_rdata,
    input  logic              ss_empty,
    // Status
    output logic              viol,
    output logic [DATA_W-1:0] viol_exp,
    output logic [DATA_W-1:0] viol_act,
    output logic              fault,
    input  logic              clr,
    output logic              ovf,
    output logic [CNT_W-1:0]  cnt_call,
    output logic [CNT_W-1:0]  cnt_ret,
    output logic [CNT_W-1:0]  cnt_viol
);

    chk_state_e        state_q, state_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [DATA_W-1:0] act_q, act_d;
    logic              forced_q, forced_d;
    logic              viol_q, viol_d;
    logic [DATA_W-1:0] viol_exp_q, viol_exp_d;
    logic [DATA_W-1:0] viol_act_q, viol_act_d;
    logic              ovf_q, ovf_d;

    ev_type_e          ev_kind;
    logic              accept;
    logic              inc_call;
    logic              inc_ret;
    logic              inc_viol;

    assign ev_kind = decode_ev(ev_type);

    // FSM next state, stack handshake, capture of compare operands and counter strobes.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        act_d      = act_q;
        forced_d   = forced_q;
        viol_d     = 1'b0;
        viol_exp_d = viol_exp_q;
        viol_act_d = viol_act_q;
        ovf_d      = ovf_q;
        ev_ready   = 1'b0;
        accept     = 1'b0;
        ss_push    = 1'b0;
        ss_pop     = 1'b0;
        inc_call   = 1'b0;
        inc_ret    = 1'b0;
        inc_viol   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gating with rstn keeps the stack untouched while reset is held.
                ev_ready = rstn;
                accept   = ev_valid && rstn;
                if (accept) begin
                    case (ev_kind)
                        EvCall: begin
                            inc_call = 1'b1;
                            if (!ss_full) begin
                                ss_push = 1'b1;
                            end else begin
                                // Dropped push: later RETs may mis-compare, so remember it.
                                ovf_d = 1'b1;
                            end
                        end
                        EvRet: begin
                            inc_ret = 1'b1;
                            if (!ss_empty) begin
                                ss_pop   = 1'b1;
                                exp_d    = ss_rdata;
                                act_d    = ev_addr;
                                forced_d = 1'b0;
                                state_d  = StCmp;
                            end else if (STRICT_UNDERFLOW) begin
                                exp_d    = '0;
                                act_d    = ev_addr;
                                forced_d = 1'b1;
                                state_d  = StCmp;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StCmp: begin
                if ((exp_q != act_q) || forced_q) begin
                    viol_d     = 1'b1;
                    viol_exp_d = exp_q;
                    viol_act_d = act_q;
                    inc_viol   = 1'b1;
                    state_d    = StFault;
                end else begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                if (clr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            exp_q      <= '0;
            act_q      <= '0;
            forced_q   <= 1'b0;
            viol_q     <= 1'b0;
            viol_exp_q <= '0;
            viol_act_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            act_q      <= act_d;
            forced_q   <= forced_d;
            viol_q     <= viol_d;
            viol_exp_q <= viol_exp_d;
            viol_act_q <= viol_act_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ss_wdata = ss_push ? ev_addr : '0;
    assign viol     = viol_q;
    assign viol_exp = viol_exp_q;
    assign viol_act = viol_act_q;
    assign fault    = (state_q == StFault);
    assign ovf      = ovf_q;

    ras_sat_counter #(
        .W (CNT_W)
    ) u_cnt_call (
        .clk   (clk),
        .clear (~rstn),
        .inc   (inc_call),
        .cnt   (cnt_call)
    );

    ras_sat_counter #(
        .W (CNT_W)
    ) u_cnt_ret (
        .clk   (clk),
        .clear (~rstn),
        .inc   (inc_ret),
        .cnt   (cnt_ret)
    );

    ras_sat_counter #(
        .W (CNT_W)
    ) u_cnt_viol (
        .clk   (clk),
        .clear (~rstn),
        .inc   (inc_viol),
        .cnt   (cnt_viol)
    );

endmodule

// File: tb/tb_ras_shadow_checker.sv
// Directed bench: strict checker with 2-bit counters on a modelled stack, plus a
// non-strict checker on a permanently empty stack for the lax underflow case.
module tb_ras_shadow_checker;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Shared event lines; each instance has its own valid.
    logic        ev_valid, b_valid, clr, force_full;
    logic [1:0]  ev_type;
    logic [31:0] ev_addr;

    // Strict instance (A)
    logic        a_ready, a_push, a_pop, a_full, a_empty, a_viol, a_fault, a_ovf;
    logic [31:0] a_wdata, a_rdata, a_vexp, a_vact;
    logic [1:0]  a_cc, a_cr, a_cv;

    // Lax instance (B)
    logic        b_ready, b_push, b_pop, b_viol, b_fault, b_ovf;
    logic [31:0] b_wdata, b_vexp, b_vact;
    logic [15:0] b_cc, b_cr, b_cv;

    ras_shadow_checker #(.DATA_W(32), .CNT_W(2), .STRICT_UNDERFLOW(1'b1)) u_dut (
        .clk(clk), .rstn(rstn),
        .ev_valid(ev_valid), .ev_ready(a_ready), .ev_type(ev_type), .ev_addr(ev_addr),
        .ss_push(a_push), .ss_wdata(a_wdata), .ss_full(a_full),
        .ss_pop(a_pop), .ss_rdata(a_rdata), .ss_empty(a_empty),
        .viol(a_viol), .viol_exp(a_vexp), .viol_act(a_vact), .fault(a_fault), .clr(clr),
        .ovf(a_ovf), .cnt_call(a_cc), .cnt_ret(a_cr), .cnt_viol(a_cv)
    );

    ras_shadow_checker #(.DATA_W(32), .CNT_W(16), .STRICT_UNDERFLOW(1'b0)) u_dut_lax (
        .clk(clk), .rstn(rstn),
        .ev_valid(b_valid), .ev_ready(b_ready), .ev_type(ev_type), .ev_addr(ev_addr),
        .ss_push(b_push), .ss_wdata(b_wdata), .ss_full(1'b0),
        .ss_pop(b_pop), .ss_rdata(32'hdead_beef), .ss_empty(1'b1),
        .viol(b_viol), .viol_exp(b_vexp), .viol_act(b_vact), .fault(b_fault), .clr(clr),
        .ovf(b_ovf), .cnt_call(b_cc), .cnt_ret(b_cr), .cnt_viol(b_cv)
    );

    // Eight-entry stack model for instance A; force_full fakes a full stack.
    logic [31:0] stk [0:7];
    int          sp = 0;
    assign a_empty = (sp == 0);
    assign a_full  = force_full || (sp == 8);
    assign a_rdata = (sp != 0) ? stk[3'(sp - 1)] : 32'h0;

    // Stack update on push/pop strobes.
    always @(posedge clk) begin
        if (a_push && !a_pop) begin
            stk[3'(sp)] <= a_wdata;
            sp          <= sp + 1;
        end else if (a_pop && !a_push) begin
            sp <= sp - 1;
        end
    end

    // Checking state and reference model.
    int n_checks = 0;
    int n_errors = 0;
    int e_call = 0, e_ret = 0, e_viol = 0;
    logic e_ovf = 1'b0;
    logic [31:0] calls[$];
    typedef struct packed {
        logic        viol;
        logic [31:0] e;
        logic [31:0] a;
    } res_t;
    res_t sb[$];

    // Values sampled mid-cycle by send().
    logic s_ready, s_push, s_pop, sb_pop, sb_ready;
    logic [31:0] s_wdata;

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one event for one edge; combinational outputs sampled on the falling edge.
    task automatic send(input logic [1:0] t, input logic [31:0] a, input bit to_b);
        ev_type = t;
        ev_addr = a;
        if (to_b) b_valid = 1'b1;
        else      ev_valid = 1'b1;
        @(negedge clk);
        s_ready  = a_ready;
        s_push   = a_push;
        s_pop    = a_pop;
        s_wdata  = a_wdata;
        sb_pop   = b_pop;
        sb_ready = b_ready;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        b_valid  = 1'b0;
        ev_type  = 2'd0;
        ev_addr  = 32'h0;
    endtask

    task automatic do_call(input logic [31:0] addr);
        bit exp_push;
        exp_push = !force_full && (calls.size() < 8);
        e_call++;
        if (!exp_push) e_ovf = 1'b1;
        send(2'd1, addr, 1'b0);
        chk("call_ready", s_ready, 1);
        chk("call_push", s_push, exp_push);
        chk("call_no_pop", s_pop, 0);
        if (exp_push) begin
            chk("call_wdata", s_wdata, addr);
            calls.push_back(addr);
        end
        chk("call_ovf", a_ovf, e_ovf);
        chk("cnt_call", a_cc, sat3(e_call));
        chk("call_stays_idle", a_ready, 1);
    endtask

    task automatic do_ret(input logic [31:0] addr);
        res_t r, got;
        bit   had;
        had = (calls.size() != 0);
        if (had) begin
            r.e    = calls.pop_back();
            r.viol = (r.e != addr);
        end else begin
            r.e    = 32'h0;
            r.viol = 1'b1;
        end
        r.a = addr;
        sb.push_back(r);
        e_ret++;
        send(2'd2, addr, 1'b0);
        chk("ret_ready", s_ready, 1);
        chk("ret_pop", s_pop, had);
        chk("ret_no_push", s_push, 0);
        chk("cmp_not_ready", a_ready, 0);
        chk("cmp_no_viol_yet", a_viol, 0);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("viol", a_viol, got.viol);
        if (got.viol) begin
            e_viol++;
            chk("viol_exp", a_vexp, got.e);
            chk("viol_act", a_vact, got.a);
            chk("fault_set", a_fault, 1);
            chk("fault_not_ready", a_ready, 0);
        end else begin
            chk("back_idle", a_ready, 1);
            chk("no_fault", a_fault, 0);
        end
        chk("cnt_ret", a_cr, sat3(e_ret));
        chk("cnt_viol", a_cv, sat3(e_viol));
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        ev_valid   = 1'b0;
        b_valid    = 1'b0;
        ev_type    = 2'd0;
        ev_addr    = 32'h0;
        clr        = 1'b0;
        force_full = 1'b0;
        rstn       = 1'b0;

        // Reset: handshake and stack strobes held low, state cleared.
        ev_valid = 1'b1;
        ev_type  = 2'd1;
        ev_addr  = 32'hffff;
        @(negedge clk);
        chk("rst_ready", a_ready, 0);
        chk("rst_push", a_push, 0);
        chk("rst_pop", a_pop, 0);
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_viol", a_viol, 0);
        chk("rst_fault", a_fault, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_cnt_call", a_cc, 0);
        chk("rst_cnt_ret", a_cr, 0);
        chk("rst_viol_exp", a_vexp, 0);
        rstn = 1'b1;
        #1;
        chk("idle_ready", a_ready, 1);

        // Lax checker: RET on empty stack is ignored.
        send(2'd2, 32'h3000, 1'b1);
        chk("lax_ready", sb_ready, 1);
        chk("lax_no_pop", sb_pop, 0);
        chk("lax_stays_idle", b_ready, 1);
        @(posedge clk);
        #1;
        chk("lax_no_viol", b_viol, 0);
        chk("lax_no_fault", b_fault, 0);
        chk("lax_cnt_ret", b_cr, 1);

        // Matched CALL/RET.
        do_call(32'h1004);
        do_ret(32'h1004);

        // Reserved type behaves as NONE.
        send(2'd3, 32'h1234, 1'b0);
        chk("none_push", s_push, 0);
        chk("none_pop", s_pop, 0);
        chk("none_cnt_call", a_cc, sat3(e_call));
        chk("none_cnt_ret", a_cr, sat3(e_ret));

        // Mismatched RET: fault until clr, events ignored meanwhile.
        do_call(32'h1004);
        do_ret(32'h2000);
        @(posedge clk);
        #1;
        chk("viol_one_cycle", a_viol, 0);
        chk("fault_sticky", a_fault, 1);
        chk("viol_exp_hold", a_vexp, 32'h1004);
        send(2'd1, 32'h7777, 1'b0);
        chk("fault_ev_ready", s_ready, 0);
        chk("fault_no_push", s_push, 0);
        chk("fault_cnt_call", a_cc, sat3(e_call));
        pulse_clr();
        chk("clr_fault", a_fault, 0);
        chk("clr_ready", a_ready, 1);
        chk("clr_viol_act_hold", a_vact, 32'h2000);

        // Strict underflow.
        do_ret(32'h3000);
        pulse_clr();
        chk("clr2_ready", a_ready, 1);

        // CALL on a full stack: overflow, no push, no violation.
        force_full = 1'b1;
        do_call(32'h5000);
        force_full = 1'b0;
        @(posedge clk);
        #1;
        chk("ovf_no_viol", a_viol, 0);
        pulse_clr();
        chk("ovf_survives_clr", a_ovf, 1);
        chk("clr_idle_ready", a_ready, 1);

        // Reset while a mismatching compare is pending.
        do_call(32'h40);
        void'(calls.pop_back());
        ev_type  = 2'd2;
        ev_addr  = 32'h44;
        ev_valid = 1'b1;
        @(negedge clk);
        chk("rc_pop", a_pop, 1);
        @(posedge clk);
        #1;
        ev_type = 2'd1;
        ev_addr = 32'h99;
        rstn    = 1'b0;
        #1;
        chk("rc_ready", a_ready, 0);
        chk("rc_push", a_push, 0);
        chk("rc_pop_low", a_pop, 0);
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        chk("rc_viol", a_viol, 0);
        chk("rc_fault", a_fault, 0);
        chk("rc_ovf", a_ovf, 0);
        chk("rc_cnt_call", a_cc, 0);
        chk("rc_cnt_ret", a_cr, 0);
        chk("rc_cnt_viol", a_cv, 0);
        chk("rc_viol_exp", a_vexp, 0);
        chk("rc_viol_act", a_vact, 0);
        @(posedge clk);
        #1;
        chk("rc_viol_late", a_viol, 0);
        rstn   = 1'b1;
        e_call = 0;
        e_ret  = 0;
        e_viol = 0;
        e_ovf  = 1'b0;
        calls.delete();
        sb.delete();
        #1;
        chk("rc_idle", a_ready, 1);

        // Counter saturation with 2-bit counters.
        for (int i = 0; i < 5; i++) begin
            do_call(32'h100 + 32'(i) * 32'd4);
            do_ret(32'h100 + 32'(i) * 32'd4);
        end
        chk("sat_cnt_call", a_cc, 3);
        chk("sat_cnt_ret", a_cr, 3);
        chk("sat_cnt_viol", a_cv, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
